// File: rtl/bcd_pkg.sv
// Shared constants and state type for the digit-serial BCD adder.
package bcd_pkg;

   localparam int unsigned BCD_DIGIT_W   = 4;
   localparam logic [3:0]  BCD_MAX_DIGIT = 4'd9;
   localparam logic [3:0]  BCD_ADJUST    = 4'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } bcd_state_e;

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD add with decimal adjust: d = (a+b+ci) mod 10, co = (a+b+ci) > 9.
module bcd_digit_add
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] a,
   input  logic [BCD_DIGIT_W-1:0] b,
   input  logic                   ci,
   output logic [BCD_DIGIT_W-1:0] d,
   output logic                   co
);

   logic [BCD_DIGIT_W:0] s;

   // Binary sum, then +6 correction whenever it leaves the decimal range.
   always_comb begin
      s  = (BCD_DIGIT_W+1)'(a) + (BCD_DIGIT_W+1)'(b) + (BCD_DIGIT_W+1)'(ci);
      co = (s > (BCD_DIGIT_W+1)'(BCD_MAX_DIGIT));
      d  = co ? (s[BCD_DIGIT_W-1:0] + BCD_ADJUST) : s[BCD_DIGIT_W-1:0];
   end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial BCD adder, LSD first, one digit per clock, valid/ready on both sides.
// Optional input-digit check enabled by defining BCD_ADD_INVALID_CHK_EN.
module bcd_serial_adder
   import bcd_pkg::*;
#(
   parameter int unsigned DIGITS = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] A,
   input  logic [BCD_DIGIT_W*DIGITS-1:0] B,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0] Y,
   output logic                          cout,
   output logic                          out_valid,
   input  logic                          out_ready
`ifdef BCD_ADD_INVALID_CHK_EN
   ,
   output logic                          invalid
`endif
);

   localparam int unsigned W     = BCD_DIGIT_W * DIGITS;
   localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

   bcd_state_e             state;
   logic [W-1:0]           a_q;
   logic [W-1:0]           b_q;
   logic [IDX_W-1:0]       idx;
   logic                   carry;
   logic [BCD_DIGIT_W-1:0] a_dig_c;
   logic [BCD_DIGIT_W-1:0] b_dig_c;
   logic [BCD_DIGIT_W-1:0] sum_dig_c;
   logic                   co_c;

   assign a_dig_c = a_q[BCD_DIGIT_W*idx +: BCD_DIGIT_W];
   assign b_dig_c = b_q[BCD_DIGIT_W*idx +: BCD_DIGIT_W];

   bcd_digit_add u_digit (
      .a  (a_dig_c),
      .b  (b_dig_c),
      .ci (carry),
      .d  (sum_dig_c),
      .co (co_c)
   );

`ifdef BCD_ADD_INVALID_CHK_EN
   logic bad_c;

   // Flag any operand digit outside 0..9 at the point of acceptance.
   always_comb begin
      bad_c = 1'b0;
      for (int i = 0; i < int'(DIGITS); i++) begin
         if ((A[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_MAX_DIGIT) ||
             (B[BCD_DIGIT_W*i +: BCD_DIGIT_W] > BCD_MAX_DIGIT))
            bad_c = 1'b1;
      end
   end
`endif

   // Sequencer: accept operands, ripple one digit per cycle, hold result until taken.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         a_q       <= '0;
         b_q       <= '0;
         idx       <= '0;
         carry     <= 1'b0;
         Y         <= '0;
         cout      <= 1'b0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
`ifdef BCD_ADD_INVALID_CHK_EN
         invalid   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= A;
                  b_q      <= B;
                  Y        <= '0;
                  cout     <= 1'b0;
                  carry    <= 1'b0;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= ADD;
`ifdef BCD_ADD_INVALID_CHK_EN
                  invalid  <= bad_c;
`endif
               end
            end
            ADD: begin
               Y[BCD_DIGIT_W*idx +: BCD_DIGIT_W] <= sum_dig_c;
               carry <= co_c;
               if (idx == IDX_LAST) begin
                  cout      <= co_c;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
`ifdef BCD_ADD_INVALID_CHK_EN
                  invalid   <= 1'b0;
`endif
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Self-checking bench for bcd_serial_adder (DIGITS=3) against a decimal-arithmetic model.
// Define BCD_ADD_INVALID_CHK_EN to also exercise the invalid-digit flag.
module tb_bcd_serial_adder;

   localparam int unsigned DIGITS = 3;
   localparam int unsigned W      = 4 * DIGITS;
   localparam int          MODULUS = 1000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [W-1:0] A, B;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] Y;
   logic         cout;
   logic         out_valid;
   logic         out_ready;
`ifdef BCD_ADD_INVALID_CHK_EN
   logic         invalid;
`endif

   int vectors = 0;
   int miscompares = 0;

   bcd_serial_adder #(.DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .A         (A),
      .B         (B),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .Y         (Y),
      .cout      (cout),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef BCD_ADD_INVALID_CHK_EN
      ,
      .invalid   (invalid)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int bcd2int(input logic [W-1:0] v);
      int r = 0;
      int p = 1;
      for (int i = 0; i < int'(DIGITS); i++) begin
         r += int'(v[4*i +: 4]) * p;
         p *= 10;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] int2bcd(input int n);
      logic [W-1:0] r = '0;
      int m = n;
      for (int i = 0; i < int'(DIGITS); i++) begin
         r[4*i +: 4] = 4'(m % 10);
         m = m / 10;
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_bcd();
      return int2bcd(int'($urandom_range(0, MODULUS - 1)));
   endfunction

   // Present operands, check latency and result against decimal arithmetic, then consume.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
      int cyc;
      int sum;
      cyc = 0;
      while (!in_ready && cyc < 20) begin
         tick();
         cyc++;
      end
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      A = a;
      B = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      A = '0;
      B = '0;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      sum = bcd2int(a) + bcd2int(b);
      check({tag, "_latency"}, 32'(cyc), 32'(DIGITS));
      check({tag, "_Y"}, 32'(Y), 32'(int2bcd(sum % MODULUS)));
      check({tag, "_cout"}, 32'(cout), 32'(sum >= MODULUS));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      logic [W-1:0] y_hold;
      int cyc;
      rst_n = 1'b0;
      A = '0;
      B = '0;
      in_valid = 1'b0;
      out_ready = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_Y", 32'(Y), 32'd0);
      check("rst_cout", 32'(cout), 32'd0);
      rst_n = 1'b1;
      tick();

      // Directed sums, including carry chains and boundaries
      do_op(12'h123, 12'h456, "t2");
      do_op(12'h058, 12'h047, "chain");
      do_op(12'h999, 12'h001, "wrap");
      do_op(12'h999, 12'h999, "max");
      do_op(12'h000, 12'h000, "zero");

      // Result held while consumer stalls; new operands ignored
      A = 12'h500;
      B = 12'h500;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      check("stall_latency", 32'(cyc), 32'(DIGITS));
      for (int i = 0; i < 5; i++) begin
         A = 12'h111;
         B = 12'h222;
         in_valid = (i % 2 == 0);
         tick();
         check("stall_Y", 32'(Y), 32'h000);
         check("stall_cout", 32'(cout), 32'd1);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_in_ready", 32'(in_ready), 32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("stall_release_valid", 32'(out_valid), 32'd0);
      check("stall_release_ready", 32'(in_ready), 32'd1);

      // Reset in the middle of an addition
      A = 12'h777;
      B = 12'h888;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      check("midrst_in_ready", 32'(in_ready), 32'd1);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      check("midrst_Y", 32'(Y), 32'd0);
      rst_n = 1'b1;
      y_hold = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         y_hold = y_hold | {{(W-1){1'b0}}, out_valid};
      end
      check("midrst_no_valid", 32'(y_hold), 32'd0);
      do_op(12'h001, 12'h002, "after_rst");

      // Random operands
      for (int n = 0; n < 25; n++) begin
         do_op(rand_bcd(), rand_bcd(), $sformatf("rnd%0d", n));
      end

`ifdef BCD_ADD_INVALID_CHK_EN
      // Invalid-digit flag travels with the result
      A = 12'h0A0;
      B = 12'h000;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      check("inv_set", 32'(invalid), 32'd1);
      check("inv_Y", 32'(Y), 32'h100);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("inv_clear", 32'(invalid), 32'd0);
      A = 12'h090;
      B = 12'h000;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      check("inv_ok", 32'(invalid), 32'd0);
      check("inv_ok_Y", 32'(Y), 32'h090);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
